mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer beside the single-cycle ALU in the MIPS CPU datapath.
- Accepts mult/multu/div/divu/mthi/mtlo requests from the decode stage, owns the HI/LO registers and holds busy for a fixed latency.
- The stall logic uses busy so that no second MD instruction and no mfhi/mflo issues while an operation is in flight.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_compute.sv | 61 ++++++
 rtl/mdu_ctrl.sv | 107 ++++++++++
 tb/tb_mdu_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// mdu_pkg : shared encodings and latency defaults for the multiply/divide unit
// Rev 1.0
// ============================================================================
package mdu_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Bits needed to hold a countdown from n-1 to 0.
    function automatic int cnt_width(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_compute.sv
`default_nettype none
// ============================================================================
// mdu_compute : combinational multiply/divide result from latched operands
// Rev 1.0
// ============================================================================
module mdu_compute
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        w_mul_sx;
    logic        w_div_sx;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_dvs;
    logic [31:0] w_q;
    logic [31:0] w_r;

    // Low 64 bits of a sign-extended product equal the signed product.
    assign w_mul_sx = (op == MD_MULT);
    assign w_prod   = {{32{w_mul_sx & a[31]}}, a} * {{32{w_mul_sx & b[31]}}, b};

    // Sign-magnitude divide keeps 0x80000000 / -1 well defined.
    assign w_div_sx = (op == MD_DIV);
    assign w_neg_a  = w_div_sx & a[31];
    assign w_neg_b  = w_div_sx & b[31];
    assign w_mag_a  = w_neg_a ? (~a + 32'd1) : a;
    assign w_mag_b  = w_neg_b ? (~b + 32'd1) : b;
    assign w_dvs    = (b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q      = w_mag_a / w_dvs;
    assign w_r      = w_mag_a % w_dvs;

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: begin
                res_hi = w_prod[63:32];
                res_lo = w_prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_lo   = (w_neg_a ^ w_neg_b) ? (~w_q + 32'd1) : w_q;
                res_hi   = w_neg_a ? (~w_r + 32'd1) : w_r;
                div_zero = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// mdu_ctrl : fixed-latency multiply/divide sequencer owning the HI/LO registers
// Rev 1.0
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = cnt_width(MAX_CYC);

    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [2:0]       r_op;

    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;

    mdu_compute u_compute (
        .op       (r_op),
        .a        (r_a),
        .b        (r_b),
        .res_hi   (w_res_hi),
        .res_lo   (w_res_lo),
        .div_zero (w_div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                r_a     <= a;
                                r_b     <= b;
                                r_op    <= md_op;
                                r_cnt   <= (md_op == MD_DIV || md_op == MD_DIVU) ?
                                           C_DIV_LOAD : C_MUL_LOAD;
                                r_busy  <= 1'b1;
                                r_state <= RUN;
                            end
                            MD_MTHI: r_hi <= a;
                            MD_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // start is deliberately ignored here, including on the final edge.
                    if (r_cnt == '0) begin
                        if (!w_div_zero) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mdu_ctrl : scoreboard bench for mdu_ctrl against a cycle-count reference
// Rev 1.0
// ============================================================================
module tb_mdu_ctrl;

    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_left = 0;
    logic [31:0] m_res_hi;
    logic [31:0] m_res_lo;
    bit          m_wr;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected output event, expected none at %0t", name, $time);
    endfunction

    // Reference arithmetic in plain 64-bit integers.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                                   output logic [31:0] rh, output logic [31:0] rl, output bit wr);
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        wr  = 1'b1;
        rh  = 32'd0;
        rl  = 32'd0;
        case (op)
            3'd0: begin p = 64'(sa * sbv); rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin p = {32'd0, av} * {32'd0, bv}; rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin
                if (bv == 32'd0) wr = 1'b0;
                else begin q = sa / sbv; r = sa % sbv; rl = q[31:0]; rh = r[31:0]; end
            end
            default: begin
                if (bv == 32'd0) wr = 1'b0;
                else begin rl = av / bv; rh = av % bv; end
            end
        endcase
    endfunction

    function automatic void model_edge(input bit s, input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wr) begin
                m_hi = m_res_hi;
                m_lo = m_res_lo;
            end
        end else if (s) begin
            if (op <= 3'd3) begin
                ref_op(op, av, bv, m_res_hi, m_res_lo, m_wr);
                m_left = (op >= 3'd2) ? DIVN : MULN;
                sb.push_back('{hi: m_wr ? m_res_hi : m_hi, lo: m_wr ? m_res_lo : m_lo,
                               pre_hi: m_hi, pre_lo: m_lo, len: m_left});
            end else if (op == 3'd4) begin
                if (av != m_hi) sb.push_back('{hi: av, lo: m_lo, pre_hi: m_hi, pre_lo: m_lo, len: 0});
                m_hi = av;
            end else if (op == 3'd5) begin
                if (av != m_lo) sb.push_back('{hi: m_hi, lo: av, pre_hi: m_hi, pre_lo: m_lo, len: 0});
                m_lo = av;
            end
        end
    endfunction

    task automatic step(input bit s, input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = s;
        md_op = op;
        a     = av;
        b     = bv;
        @(posedge clk);
        model_edge(s, op, av, bv);
        #1;
    endtask

    task automatic wait_done(input bit noisy);
        int guard = 0;
        while (m_left > 0 && guard < 64) begin
            step(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
            guard++;
        end
    endtask

    // Monitor: pops an expectation whenever busy falls or hi/lo change while idle.
    bit          mon_prev_busy = 1'b0;
    int          mon_cnt = 0;
    logic [63:0] mon_last = 64'd0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (reset) begin
            mon_prev_busy = 1'b0;
            mon_cnt       = 0;
            mon_last      = {hi, lo};
        end else begin
            if (busy) begin
                if (!mon_prev_busy) mon_cnt = 0;
                mon_cnt++;
                if (sb.size() == 0) fail_now("busy_without_request");
                else begin
                    chk("hold_hi", hi, sb[0].pre_hi);
                    chk("hold_lo", lo, sb[0].pre_lo);
                end
            end else if (mon_prev_busy || ({hi, lo} != mon_last)) begin
                if (sb.size() == 0) fail_now("unexpected_write");
                else begin
                    mon_e = sb.pop_front();
                    chk("res_hi", hi, mon_e.hi);
                    chk("res_lo", lo, mon_e.lo);
                    chk("busy_len", mon_prev_busy ? 32'(mon_cnt) : 32'd0, 32'(mon_e.len));
                end
            end
            mon_prev_busy = busy;
            mon_last      = {hi, lo};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        #2 reset = 1'b0;

        // Signed multiply
        step(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done(1'b0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // divu with live operands churning while busy
        step(1'b1, 3'd3, 32'd100, 32'd7);
        wait_done(1'b0);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        step(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b1);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        step(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b1);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);

        // mthi/mtlo back-to-back, then divide by zero
        step(1'b1, 3'd4, 32'h1234, 32'd0);
        step(1'b1, 3'd5, 32'h5678, 32'd0);
        chk("mt_hi", hi, 32'h1234);
        chk("mt_lo", lo, 32'h5678);
        chk("mt_busy", 32'(busy), 32'd0);
        step(1'b1, 3'd2, 32'd55, 32'd0);
        wait_done(1'b0);
        chk("dz_hi", hi, 32'h1234);
        chk("dz_lo", lo, 32'h5678);

        // Starts during busy cycles 2 and 5 (completion) are dropped
        step(1'b1, 3'd0, 32'd3, 32'd5);
        step(1'b0, 3'd5, 32'hDEAD, 32'd0);
        step(1'b1, 3'd5, 32'hDEAD, 32'd0);
        step(1'b0, 3'd5, 32'hDEAD, 32'd0);
        step(1'b0, 3'd5, 32'hDEAD, 32'd0);
        step(1'b1, 3'd5, 32'hDEAD, 32'd0);
        chk("late_start_lo", lo, 32'd15);
        chk("late_start_busy", 32'(busy), 32'd0);
        step(1'b1, 3'd5, 32'hDEAD, 32'd0);
        chk("cyc6_lo", lo, 32'hDEAD);

        // Asynchronous reset during busy cycle 4
        step(1'b1, 3'd3, 32'd1000, 32'd3);
        step(1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b0, 3'd0, 32'd0, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        sb.delete();
        m_left = 0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        repeat (DIVN + 4) step(1'b0, 3'd0, $urandom, $urandom);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);

        // Randomized traffic including reserved ops and protocol-error starts
        for (int i = 0; i < 80; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            step(1'b1, rop, ra, rb);
            wait_done(1'b1);
            repeat ($urandom_range(0, 2)) step(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        repeat (3) step(1'b0, 3'd0, 32'd0, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
